bcd_display_driver: RTL

Downstream consumer of the 14-bit up/down BCD-range counter (0–9999). Converts the binary count to four packed BCD digits with a sequential shift-add-3 (double-dabble) engine. Time-multiplexes the digits onto a 4-digit common-anode 7-segment display. Sits between the counter output and the board display pins.

---
 rtl/bcd_display_driver_if.sv | 29 ++
 rtl/bcd_display_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_driver_if.sv
// Interface bundling the binary count input with the converted BCD value
// and the multiplexed 7-segment display pins.
interface bcd_display_driver_if #(
  parameter int N = 14
);
  logic [N-1:0] count;
  logic [15:0]  bcd;
  logic         valid;
  logic [3:0]   an;
  logic [6:0]   seg;

  // Counter / board side: drives the count, observes the converted value and pins
  modport master (
    output count,
    input  bcd,
    input  valid,
    input  an,
    input  seg
  );

  // Display driver side
  modport slave (
    input  count,
    output bcd,
    output valid,
    output an,
    output seg
  );
endinterface

// File: rtl/bcd_display_driver.sv
// Binary-to-BCD conversion (sequential double-dabble, clamped to 9999) and
// 4-digit common-anode 7-segment multiplexing with leading-zero blanking.
module bcd_display_driver #(
  parameter int N           = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_display_driver_if.slave  bus
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  localparam int IW = $clog2(N + 1);
  localparam int RW = $clog2(REFRESH_DIV);

  localparam logic [N-1:0]  MAX_BIN  = N'(32'd9999);
  localparam logic [IW-1:0] LAST_IT  = IW'(N - 1);
  localparam logic [RW-1:0] LAST_REF = RW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_BLANK = 7'b1111111;

  logic [1:0]    state_r;
  logic [N-1:0]  bin_r;
  logic [15:0]   scratch_r;
  logic [IW-1:0] iter_r;
  logic [15:0]   bcd_r;
  logic          valid_r;
  logic [RW-1:0] refresh_r;
  logic [1:0]    digit_r;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;

  logic [3:0]    nib_s;
  logic          blank_s;
  logic [3:0]    an_s;
  logic [6:0]    seg_s;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift
  function automatic logic [15:0] add3(input logic [15:0] s);
    logic [15:0] r;
    logic [3:0]  nib;
    r = s;
    for (int i = 0; i < 4; i++) begin
      nib = s[4*i +: 4];
      if (nib >= 4'd5) begin
        r[4*i +: 4] = nib + 4'd3;
      end else begin
        r[4*i +: 4] = nib;
      end
    end
    return r;
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles blank
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Conversion FSM: LOAD samples and clamps, SHIFT runs N double-dabble steps, LATCH publishes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_LOAD;
      bin_r     <= '0;
      scratch_r <= 16'h0000;
      iter_r    <= '0;
      bcd_r     <= 16'h0000;
      valid_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_LOAD: begin
          bin_r     <= (bus.count > MAX_BIN) ? MAX_BIN : bus.count;
          scratch_r <= 16'h0000;
          iter_r    <= '0;
          state_r   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          {scratch_r, bin_r} <= {add3(scratch_r), bin_r} << 1;
          iter_r <= iter_r + IW'(1);
          if (iter_r == LAST_IT) begin
            state_r <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          bcd_r   <= scratch_r;
          valid_r <= 1'b1;
          state_r <= ST_LOAD;
        end
        default: begin
          state_r <= ST_LOAD;
        end
      endcase
    end
  end

  // Refresh divider and digit index: each digit stays selected REFRESH_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_r <= '0;
      digit_r   <= 2'd0;
    end else if (refresh_r == LAST_REF) begin
      refresh_r <= '0;
      digit_r   <= digit_r + 2'd1;
    end else begin
      refresh_r <= refresh_r + RW'(1);
    end
  end

  // Select the current digit, apply leading-zero blanking and decode it
  always_comb begin
    nib_s   = 4'd0;
    blank_s = 1'b0;
    an_s    = 4'b1110;
    case (digit_r)
      2'd0: begin
        nib_s   = bcd_r[3:0];
        blank_s = 1'b0;
        an_s    = 4'b1110;
      end
      2'd1: begin
        nib_s   = bcd_r[7:4];
        blank_s = (bcd_r[15:4] == 12'h000);
        an_s    = 4'b1101;
      end
      2'd2: begin
        nib_s   = bcd_r[11:8];
        blank_s = (bcd_r[15:8] == 8'h00);
        an_s    = 4'b1011;
      end
      2'd3: begin
        nib_s   = bcd_r[15:12];
        blank_s = (bcd_r[15:12] == 4'h0);
        an_s    = 4'b0111;
      end
      default: begin
        nib_s   = 4'd0;
        blank_s = 1'b1;
        an_s    = 4'b1111;
      end
    endcase
    if (blank_s) begin
      seg_s = SEG_BLANK;
    end else begin
      seg_s = seg7(nib_s);
    end
  end

  // Register digit enable and segments together so the pins change on one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r  <= 4'b1110;
      seg_r <= 7'b1000000;
    end else begin
      an_r  <= an_s;
      seg_r <= seg_s;
    end
  end

  assign bus.bcd   = bcd_r;
  assign bus.valid = valid_r;
  assign bus.an    = an_r;
  assign bus.seg   = seg_r;

endmodule
